tx_fc_update_decoder: RTL and testbench

//  Decodes received flow-control DLLPs (InitFC1, InitFC2, UpdateFC) from the Data Link Layer.

---
 rtl/tx_fc_update_decoder_if.sv | 38 +++
 rtl/tx_fc_update_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_tx_fc_update_decoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_fc_update_decoder_if.sv
// ---------------------------------------------------------------------------
// tx_fc_update_decoder_if
// Received flow-control DLLP fields as delivered by the Data Link Layer.
// One DLLP per cycle at most; there is no backpressure.
//   dllp_valid       fields below are valid this cycle
//   dllp_type        DLLP byte 0 {type[7:4], 0, VC[2:0]}
//   dllp_hdr_scale   HdrScale
//   dllp_hdr_fc      raw HdrFC
//   dllp_data_scale  DataScale
//   dllp_data_fc     raw DataFC
// Modports: master = DLL side (drives), slave = decoder side (receives).
// ---------------------------------------------------------------------------
interface tx_fc_update_decoder_if;
  logic        dllp_valid;
  logic [7:0]  dllp_type;
  logic [1:0]  dllp_hdr_scale;
  logic [7:0]  dllp_hdr_fc;
  logic [1:0]  dllp_data_scale;
  logic [11:0] dllp_data_fc;

  modport master (
    output dllp_valid,
    output dllp_type,
    output dllp_hdr_scale,
    output dllp_hdr_fc,
    output dllp_data_scale,
    output dllp_data_fc
  );

  modport slave (
    input dllp_valid,
    input dllp_type,
    input dllp_hdr_scale,
    input dllp_hdr_fc,
    input dllp_data_scale,
    input dllp_data_fc
  );
endinterface

// File: rtl/tx_fc_update_decoder.sv
// ---------------------------------------------------------------------------
// tx_fc_update_decoder
// Decodes received InitFC1 / InitFC2 / UpdateFC DLLPs for one VC, runs the
// FC-initialisation state machine and drives one scaled credit-limit update
// per cycle towards Tx_FC (upstream of the Tx arbiter credit check).
//
// Ports
//   clk            clock, rising edge
//   arst           asynchronous reset, active low
//   dl_up          DL_Up from the DLL; low = link down
//   dllp           received DLLP fields (slave modport)
//   TypeFC         FC_X / FC_P / FC_NP / FC_CPL, one-cycle pulse per update
//   HdrFC          scaled header credit limit (held between updates)
//   DataFC         scaled data credit limit (held between updates)
//   fc_init_state  00 = FC_INIT1, 01 = FC_INIT2, 10 = FC_ACTIVE
//   fc_init_done   high in FC_ACTIVE
//   fc_inf         infinite flags {cpl_d, cpl_h, np_d, np_h, p_d, p_h}
//
// States
//   state     | meaning
//   FC_INIT1  | collecting first InitFC1 of P, NP and Cpl
//   FC_INIT2  | all InitFC1 seen, waiting for InitFC2 or UpdateFC
//   FC_ACTIVE | initialisation done, UpdateFC forwarded
// ---------------------------------------------------------------------------
module tx_fc_update_decoder #(
  parameter int         FC_HDR_WIDTH  = 12,
  parameter int         FC_DATA_WIDTH = 16,
  parameter logic [2:0] VC_ID         = 3'd0
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      dl_up,
  tx_fc_update_decoder_if.slave     dllp,
  output logic [1:0]                TypeFC,
  output logic [FC_HDR_WIDTH-1:0]   HdrFC,
  output logic [FC_DATA_WIDTH-1:0]  DataFC,
  output logic [1:0]                fc_init_state,
  output logic                      fc_init_done,
  output logic [5:0]                fc_inf
);

  typedef enum logic [1:0] {
    FC_INIT1  = 2'b00,
    FC_INIT2  = 2'b01,
    FC_ACTIVE = 2'b10
  } fc_state_e;

  // Tx arbiter FC type encoding
  localparam logic [1:0] FC_X   = 2'd0;
  localparam logic [1:0] FC_P   = 2'd1;
  localparam logic [1:0] FC_NP  = 2'd2;
  localparam logic [1:0] FC_CPL = 2'd3;

  fc_state_e                 state, state_nxt;
  logic [2:0]                mask, mask_nxt;
  logic [5:0]                inf_nxt;
  logic [1:0]                type_nxt;
  logic [FC_HDR_WIDTH-1:0]   hdr_nxt;
  logic [FC_DATA_WIDTH-1:0]  data_nxt;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [3:0]  type_hi;
  logic [1:0]  cls;
  logic [2:0]  cls_oh;
  logic [1:0]  cls_type;
  logic        vc_match;
  logic        accepted;
  logic        is_init1;
  logic        is_init2;
  logic        is_upd;

  assign type_hi  = dllp.dllp_type[7:4];
  assign cls      = type_hi[1:0];
  assign vc_match = (dllp.dllp_type[3] == 1'b0) && (dllp.dllp_type[2:0] == VC_ID);
  assign accepted = dllp.dllp_valid && dl_up && vc_match;

  // cls 11 is not a valid FC type in any of the three groups
  assign is_init1 = accepted && (type_hi[3:2] == 2'b01) && (cls != 2'b11);
  assign is_init2 = accepted && (type_hi[3:2] == 2'b11) && (cls != 2'b11);
  assign is_upd   = accepted && (type_hi[3:2] == 2'b10) && (cls != 2'b11);

  always_comb begin
    cls_oh   = 3'b000;
    cls_type = FC_X;
    case (cls)
      2'b00: begin cls_oh = 3'b001; cls_type = FC_P;   end
      2'b01: begin cls_oh = 3'b010; cls_type = FC_NP;  end
      2'b10: begin cls_oh = 3'b100; cls_type = FC_CPL; end
      default: begin cls_oh = 3'b000; cls_type = FC_X; end
    endcase
  end

  // ---------------------------------------------------------------------
  // Scaling: zero-extend raw value, shift by 0/2/4, truncate to port width
  // ---------------------------------------------------------------------
  function automatic logic [2:0] scale_shift(input logic [1:0] scale);
    logic [2:0] sh;
    case (scale)
      2'b10:   sh = 3'd2;
      2'b11:   sh = 3'd4;
      default: sh = 3'd0;
    endcase
    return sh;
  endfunction

  logic [FC_HDR_WIDTH-1:0]  hdr_scaled;
  logic [FC_DATA_WIDTH-1:0] data_scaled;
  logic                     hdr_zero;
  logic                     data_zero;

  assign hdr_scaled  = FC_HDR_WIDTH'({4'b0000, dllp.dllp_hdr_fc})
                       << scale_shift(dllp.dllp_hdr_scale);
  assign data_scaled = FC_DATA_WIDTH'({4'b0000, dllp.dllp_data_fc})
                       << scale_shift(dllp.dllp_data_scale);
  assign hdr_zero    = (dllp.dllp_hdr_fc == 8'd0);
  assign data_zero   = (dllp.dllp_data_fc == 12'd0);

  // Infinite flags belonging to the decoded class, and the set pattern a
  // first InitFC1 of that class would latch.
  logic [5:0] inf_set;
  logic       cur_inf_h;
  logic       cur_inf_d;

  assign inf_set = {cls_oh[2] & data_zero, cls_oh[2] & hdr_zero,
                    cls_oh[1] & data_zero, cls_oh[1] & hdr_zero,
                    cls_oh[0] & data_zero, cls_oh[0] & hdr_zero};

  assign cur_inf_h = |(fc_inf & {1'b0, cls_oh[2], 1'b0, cls_oh[1], 1'b0, cls_oh[0]});
  assign cur_inf_d = |(fc_inf & {cls_oh[2], 1'b0, cls_oh[1], 1'b0, cls_oh[0], 1'b0});

  // ---------------------------------------------------------------------
  // FC init state machine and output next-values
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    inf_nxt   = fc_inf;
    type_nxt  = FC_X;
    hdr_nxt   = HdrFC;
    data_nxt  = DataFC;

    if (!dl_up) begin
      // Link down: drop this cycle's DLLP and restart initialisation.
      // Credit limits are intentionally held.
      state_nxt = FC_INIT1;
      mask_nxt  = 3'b000;
      inf_nxt   = 6'b000000;
    end else begin
      case (state)
        FC_INIT1: begin
          if (is_init1 && ((mask & cls_oh) == 3'b000)) begin
            type_nxt = cls_type;
            hdr_nxt  = hdr_scaled;
            data_nxt = data_scaled;
            mask_nxt = mask | cls_oh;
            inf_nxt  = fc_inf | inf_set;
            if ((mask | cls_oh) == 3'b111) begin
              state_nxt = FC_INIT2;
            end
          end
        end

        FC_INIT2: begin
          if (is_init2) begin
            state_nxt = FC_ACTIVE;
          end else if (is_upd) begin
            state_nxt = FC_ACTIVE;
            if (!(cur_inf_h && cur_inf_d)) begin
              type_nxt = cls_type;
              hdr_nxt  = cur_inf_h ? '0 : hdr_scaled;
              data_nxt = cur_inf_d ? '0 : data_scaled;
            end
          end
        end

        FC_ACTIVE: begin
          // A class with both flags infinite never needs a limit update;
          // a single infinite field is driven as zero and bypassed by Tx_FC.
          if (is_upd && !(cur_inf_h && cur_inf_d)) begin
            type_nxt = cls_type;
            hdr_nxt  = cur_inf_h ? '0 : hdr_scaled;
            data_nxt = cur_inf_d ? '0 : data_scaled;
          end
        end

        default: begin
          state_nxt = FC_INIT1;
          mask_nxt  = 3'b000;
          inf_nxt   = 6'b000000;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state  <= FC_INIT1;
      mask   <= 3'b000;
      fc_inf <= 6'b000000;
      TypeFC <= FC_X;
      HdrFC  <= '0;
      DataFC <= '0;
    end else begin
      state  <= state_nxt;
      mask   <= mask_nxt;
      fc_inf <= inf_nxt;
      TypeFC <= type_nxt;
      HdrFC  <= hdr_nxt;
      DataFC <= data_nxt;
    end
  end

  assign fc_init_state = state;
  assign fc_init_done  = (state == FC_ACTIVE);

endmodule

// File: tb/tb_tx_fc_update_decoder.sv
// ---------------------------------------------------------------------------
// tb_tx_fc_update_decoder
// Directed DLLP vectors; each expected TypeFC pulse is queued when its DLLP
// is driven and a separate monitor pops and compares whenever the DUT
// presents a non-FC_X TypeFC. State/flag checks are made inline.
// ---------------------------------------------------------------------------
module tb_tx_fc_update_decoder;

  localparam logic [1:0] FC_X   = 2'd0;
  localparam logic [1:0] FC_P   = 2'd1;
  localparam logic [1:0] FC_NP  = 2'd2;
  localparam logic [1:0] FC_CPL = 2'd3;

  localparam logic [3:0] I1P = 4'b0100;
  localparam logic [3:0] I1N = 4'b0101;
  localparam logic [3:0] I1C = 4'b0110;
  localparam logic [3:0] I2P = 4'b1100;
  localparam logic [3:0] UP  = 4'b1000;
  localparam logic [3:0] UN  = 4'b1001;
  localparam logic [3:0] UC  = 4'b1010;

  localparam logic [3:0] VC0  = 4'b0000;
  localparam logic [3:0] VC3  = 4'b0011;
  localparam logic [3:0] BIT3 = 4'b1000;

  logic        clk;
  logic        arst;
  logic        dl_up;
  logic [1:0]  TypeFC;
  logic [11:0] HdrFC;
  logic [15:0] DataFC;
  logic [1:0]  fc_init_state;
  logic        fc_init_done;
  logic [5:0]  fc_inf;

  tx_fc_update_decoder_if dif();

  tx_fc_update_decoder #(
    .FC_HDR_WIDTH  (12),
    .FC_DATA_WIDTH (16),
    .VC_ID         (3'd0)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .dl_up         (dl_up),
    .dllp          (dif),
    .TypeFC        (TypeFC),
    .HdrFC         (HdrFC),
    .DataFC        (DataFC),
    .fc_init_state (fc_init_state),
    .fc_init_done  (fc_init_done),
    .fc_inf        (fc_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  t;
    logic [11:0] h;
    logic [15:0] d;
  } pulse_t;

  pulse_t sb_q[$];
  int     n_vec = 0;
  int     n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (arst === 1'b1 && TypeFC !== FC_X) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got type %0d hdr 0x%0h data 0x%0h, expected no pulse",
                 TypeFC, HdrFC, DataFC);
      end else begin
        pulse_t e;
        e = sb_q.pop_front();
        if (TypeFC !== e.t || HdrFC !== e.h || DataFC !== e.d) begin
          n_bad++;
          $display("FAIL pulse: got type %0d hdr 0x%0h data 0x%0h, expected type %0d hdr 0x%0h data 0x%0h",
                   TypeFC, HdrFC, DataFC, e.t, e.h, e.d);
        end
      end
    end
  end

  task automatic send(input logic [3:0] hi, input logic [3:0] lo,
                      input logic [1:0] hs, input logic [7:0] h,
                      input logic [1:0] ds, input logic [11:0] d,
                      input bit exp_pulse, input logic [1:0] et,
                      input logic [11:0] eh, input logic [15:0] ed);
    @(negedge clk);
    dif.dllp_valid      = 1'b1;
    dif.dllp_type       = {hi, lo};
    dif.dllp_hdr_scale  = hs;
    dif.dllp_hdr_fc     = h;
    dif.dllp_data_scale = ds;
    dif.dllp_data_fc    = d;
    if (exp_pulse) sb_q.push_back('{et, eh, ed});
  endtask

  task automatic idle();
    @(negedge clk);
    dif.dllp_valid = 1'b0;
    dl_up          = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst                = 1'b0;
    dl_up               = 1'b1;
    dif.dllp_valid      = 1'b0;
    dif.dllp_type       = 8'h00;
    dif.dllp_hdr_scale  = 2'b00;
    dif.dllp_hdr_fc     = 8'h00;
    dif.dllp_data_scale = 2'b00;
    dif.dllp_data_fc    = 12'h000;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(fc_init_state), 32'h0);
    chk("rst_type",  32'(TypeFC), 32'(FC_X));
    chk("rst_hdr",   32'(HdrFC), 32'h0);
    chk("rst_data",  32'(DataFC), 32'h0);
    chk("rst_inf",   32'(fc_inf), 32'h0);
    chk("rst_done",  32'(fc_init_done), 32'h0);
    arst = 1'b1;

    // First init sequence, scale 01 = no shift
    send(I1P, VC0, 2'b01, 8'd30, 2'b01, 12'd1000, 1, FC_P,   12'd30, 16'd1000);
    send(I1N, VC0, 2'b01, 8'd15, 2'b01, 12'd1000, 1, FC_NP,  12'd15, 16'd1000);
    send(I1C, VC0, 2'b01, 8'd30, 2'b01, 12'd1000, 1, FC_CPL, 12'd30, 16'd1000);
    idle();
    chk("init2_state", 32'(fc_init_state), 32'h1);
    chk("init2_inf",   32'(fc_inf), 32'h0);
    send(I1P, VC0, 2'b00, 8'd1, 2'b00, 12'd1, 0, FC_X, 12'd0, 16'd0);
    idle();
    chk("init2_hold_state", 32'(fc_init_state), 32'h1);
    send(I2P, VC0, 2'b00, 8'd1, 2'b00, 12'd1, 0, FC_X, 12'd0, 16'd0);
    idle();
    chk("active_state", 32'(fc_init_state), 32'h2);
    chk("active_done",  32'(fc_init_done), 32'h1);

    // Scaling in ACTIVE
    send(UN, VC0, 2'b11, 8'hFF, 2'b10, 12'hFFF, 1, FC_NP,  12'hFF0, 16'h3FFC);
    send(UP, VC0, 2'b10, 8'd5,  2'b11, 12'd7,   1, FC_P,   12'd20,  16'd112);
    send(UC, VC0, 2'b00, 8'd1,  2'b00, 12'd2,   1, FC_CPL, 12'd1,   16'd2);

    // Ignored DLLPs in ACTIVE
    send(UP,    VC3,  2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    send(UP,    BIT3, 2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    send(4'h0,  VC0,  2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    send(I1P,   VC0,  2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    send(I2P,   VC0,  2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    idle();
    chk("ignored_state", 32'(fc_init_state), 32'h2);
    chk("held_hdr",      32'(HdrFC), 32'd1);
    chk("held_data",     32'(DataFC), 32'd2);

    // Link down in ACTIVE with a concurrent UpdateFC
    send(UP, VC0, 2'b00, 8'd9, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    dl_up = 1'b0;
    idle();
    chk("linkdown_state", 32'(fc_init_state), 32'h0);
    chk("linkdown_inf",   32'(fc_inf), 32'h0);
    chk("linkdown_hdr",   32'(HdrFC), 32'd1);
    chk("linkdown_data",  32'(DataFC), 32'd2);

    // Second init: repeats, wrong VC, wrong phase are ignored; zero credits -> infinite
    send(I1P, VC0, 2'b00, 8'd10, 2'b00, 12'd20, 1, FC_P, 12'd10, 16'd20);
    send(I1P, VC0, 2'b00, 8'd99, 2'b00, 12'd99, 0, FC_X, 12'd0, 16'd0);
    send(UP,  VC0, 2'b00, 8'd99, 2'b00, 12'd99, 0, FC_X, 12'd0, 16'd0);
    send(I2P, VC0, 2'b00, 8'd99, 2'b00, 12'd99, 0, FC_X, 12'd0, 16'd0);
    send(I1N, VC3, 2'b00, 8'd99, 2'b00, 12'd99, 0, FC_X, 12'd0, 16'd0);
    idle();
    chk("init1_ignore_state", 32'(fc_init_state), 32'h0);
    send(I1N, VC0, 2'b00, 8'd4, 2'b00, 12'd0, 1, FC_NP,  12'd4, 16'd0);
    send(I1C, VC0, 2'b10, 8'd0, 2'b11, 12'd0, 1, FC_CPL, 12'd0, 16'd0);
    idle();
    chk("zero_init_state", 32'(fc_init_state), 32'h1);
    chk("zero_init_inf",   32'(fc_inf), 32'b111000);

    // Link down in INIT2 with a concurrent UpdateFC: dropped, mask cleared
    send(UP, VC0, 2'b00, 8'd3, 2'b00, 12'd9, 0, FC_X, 12'd0, 16'd0);
    dl_up = 1'b0;
    idle();
    chk("init2_down_state", 32'(fc_init_state), 32'h0);
    chk("init2_down_inf",   32'(fc_inf), 32'h0);

    send(UC,  VC0, 2'b00, 8'd5, 2'b00, 12'd5, 0, FC_X, 12'd0, 16'd0);
    send(I1P, VC0, 2'b01, 8'd1, 2'b01, 12'd1, 1, FC_P,  12'd1, 16'd1);
    send(I1N, VC0, 2'b01, 8'd2, 2'b01, 12'd0, 1, FC_NP, 12'd2, 16'd0);
    idle();
    chk("reinit_partial_state", 32'(fc_init_state), 32'h0);
    send(I1C, VC0, 2'b00, 8'd0, 2'b00, 12'd0, 1, FC_CPL, 12'd0, 16'd0);
    idle();
    chk("reinit_state", 32'(fc_init_state), 32'h1);
    chk("reinit_inf",   32'(fc_inf), 32'b111000);

    // UpdateFC in INIT2 is forwarded and activates
    send(UP, VC0, 2'b00, 8'd3, 2'b10, 12'd9, 1, FC_P, 12'd3, 16'd36);
    idle();
    chk("upd_activate_state", 32'(fc_init_state), 32'h2);

    // Infinite handling in ACTIVE
    send(UC, VC0, 2'b01, 8'd50, 2'b01, 12'd50, 0, FC_X,  12'd0,  16'd0);
    send(UN, VC0, 2'b10, 8'd7,  2'b00, 12'd5,  1, FC_NP, 12'd28, 16'd0);
    send(UP, VC0, 2'b00, 8'd40, 2'b00, 12'd60, 1, FC_P,  12'd40, 16'd60);
    idle();
    idle();

    // Asynchronous reset mid-run
    #2;
    arst = 1'b0;
    #1;
    chk("async_rst_state", 32'(fc_init_state), 32'h0);
    chk("async_rst_type",  32'(TypeFC), 32'(FC_X));
    chk("async_rst_hdr",   32'(HdrFC), 32'h0);
    chk("async_rst_data",  32'(DataFC), 32'h0);
    chk("async_rst_inf",   32'(fc_inf), 32'h0);
    @(negedge clk);
    arst = 1'b1;
    idle();
    chk("post_rst_state", 32'(fc_init_state), 32'h0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
